// File: rtl/axis_decim_pack.sv
// rtl/axis_decim_pack.sv - keep 1 of DECIM samples, saturate to 16 bit, pack pairs into 32-bit words
// Define SAT_COUNT_EN to add the sat_count port counting clipped kept samples.
module axis_decim_pack #(
   parameter int DECIM                  = 4,
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                  s00_axis_tvalid,
   input  logic                                  s00_axis_tlast,
   output logic                                  s00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   input  logic                                  m00_axis_tready
`ifdef SAT_COUNT_EN
   ,
   output logic [15:0]                           sat_count
`endif
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HALF  = 1'b1;
   localparam logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] SAT_MAX = 32767;
   localparam logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] SAT_MIN = -32768;

   logic [PW-1:0] phase_q, phase_d;
   logic [0:0]    state_q, state_d;
   logic [15:0]   lo_q, lo_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0]     out_data_q, out_data_d;
   logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] out_strb_q, out_strb_d;

   logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] x;
   logic        clip_hi, clip_lo, keep, in_fire;
   logic [15:0] sat_s;
   logic        unused_tstrb;

   assign unused_tstrb    = ^s00_axis_tstrb;
   assign s00_axis_tready = ~s00_axis_aresetn & (~out_valid_q | m00_axis_tready);
   assign in_fire         = s00_axis_tvalid & s00_axis_tready;
   assign keep            = (phase_q == '0);

   assign x       = s00_axis_tdata;
   assign clip_hi = (x > SAT_MAX);
   assign clip_lo = (x < SAT_MIN);
   assign sat_s   = clip_hi ? 16'h7FFF : (clip_lo ? 16'h8000 : x[15:0]);

   always_comb begin
      phase_d     = phase_q;
      state_d     = state_q;
      lo_d        = lo_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_strb_d  = out_strb_q;
      out_last_d  = out_last_q;
      if (out_valid_q && m00_axis_tready) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_strb_d  = '0;
         out_last_d  = 1'b0;
      end
      if (in_fire) begin
         // A frame end re-aligns decimation so the next frame starts on a kept beat
         if (s00_axis_tlast || phase_q == PHASE_LAST) phase_d = '0;
         else                                         phase_d = phase_q + 1'b1;
         if (state_q == ST_EMPTY) begin
            if (keep && !s00_axis_tlast) begin
               lo_d    = sat_s;
               state_d = ST_HALF;
            end else if (keep) begin
               out_valid_d = 1'b1;
               out_data_d  = {16'h0000, sat_s};
               out_strb_d  = 4'b0011;
               out_last_d  = 1'b1;
            end else if (s00_axis_tlast) begin
               out_valid_d = 1'b1;
               out_data_d  = '0;
               out_strb_d  = 4'b0000;
               out_last_d  = 1'b1;
            end
         end else begin
            if (keep) begin
               out_valid_d = 1'b1;
               out_data_d  = {sat_s, lo_q};
               out_strb_d  = 4'b1111;
               out_last_d  = s00_axis_tlast;
               state_d     = ST_EMPTY;
            end else if (s00_axis_tlast) begin
               out_valid_d = 1'b1;
               out_data_d  = {16'h0000, lo_q};
               out_strb_d  = 4'b0011;
               out_last_d  = 1'b1;
               state_d     = ST_EMPTY;
            end
         end
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_aresetn) begin
         phase_q     <= '0;
         state_q     <= ST_EMPTY;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         state_q     <= state_d;
         lo_q        <= lo_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_strb_q  <= out_strb_d;
         out_last_q  <= out_last_d;
      end
   end

   assign m00_axis_tdata  = out_data_q;
   assign m00_axis_tstrb  = out_strb_q;
   assign m00_axis_tvalid = out_valid_q;
   assign m00_axis_tlast  = out_last_q;

`ifdef SAT_COUNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (in_fire && keep && (clip_hi || clip_lo) && sat_cnt_q != 16'hFFFF)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_aresetn) sat_cnt_q <= '0;
      else                  sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_decim_pack.sv
// tb/tb_axis_decim_pack.sv - directed and random checks of axis_decim_pack at DECIM 4, 1 and 2
// Connects sat_count when SAT_COUNT_EN is defined.
module tb_axis_decim_pack;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       rst;
   logic [2:0][31:0] s_tdata;
   logic [2:0][3:0]  s_tstrb;
   logic [2:0]       s_tvalid, s_tlast, m_tready;
   wire  [2:0]       s_tready, m_tvalid, m_tlast;
   wire  [2:0][31:0] m_tdata;
   wire  [2:0][3:0]  m_tstrb;
`ifdef SAT_COUNT_EN
   wire  [2:0][15:0] satc;
`endif

   axis_decim_pack #(.DECIM(4)) u_d4 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst[0]),
      .s00_axis_tdata(s_tdata[0]), .s00_axis_tstrb(s_tstrb[0]), .s00_axis_tvalid(s_tvalid[0]),
      .s00_axis_tlast(s_tlast[0]), .s00_axis_tready(s_tready[0]),
      .m00_axis_tdata(m_tdata[0]), .m00_axis_tstrb(m_tstrb[0]), .m00_axis_tvalid(m_tvalid[0]),
      .m00_axis_tlast(m_tlast[0]), .m00_axis_tready(m_tready[0])
`ifdef SAT_COUNT_EN
      , .sat_count(satc[0])
`endif
   );
   axis_decim_pack #(.DECIM(1)) u_d1 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst[1]),
      .s00_axis_tdata(s_tdata[1]), .s00_axis_tstrb(s_tstrb[1]), .s00_axis_tvalid(s_tvalid[1]),
      .s00_axis_tlast(s_tlast[1]), .s00_axis_tready(s_tready[1]),
      .m00_axis_tdata(m_tdata[1]), .m00_axis_tstrb(m_tstrb[1]), .m00_axis_tvalid(m_tvalid[1]),
      .m00_axis_tlast(m_tlast[1]), .m00_axis_tready(m_tready[1])
`ifdef SAT_COUNT_EN
      , .sat_count(satc[1])
`endif
   );
   axis_decim_pack #(.DECIM(2)) u_d2 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst[2]),
      .s00_axis_tdata(s_tdata[2]), .s00_axis_tstrb(s_tstrb[2]), .s00_axis_tvalid(s_tvalid[2]),
      .s00_axis_tlast(s_tlast[2]), .s00_axis_tready(s_tready[2]),
      .m00_axis_tdata(m_tdata[2]), .m00_axis_tstrb(m_tstrb[2]), .m00_axis_tvalid(m_tvalid[2]),
      .m00_axis_tlast(m_tlast[2]), .m00_axis_tready(m_tready[2])
`ifdef SAT_COUNT_EN
      , .sat_count(satc[2])
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int cur   = 0;
   bit rnd   = 0;

   // Words are {tlast, tstrb, tdata}
   logic [36:0] got[$];
   logic [36:0] exp_q[$];
   logic [15:0] pend[$];
   int midx   = 0;
   int expsat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (m_tvalid[cur] && m_tready[cur])
         got.push_back({m_tlast[cur], m_tstrb[cur], m_tdata[cur]});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      if (v > 32767)       return 16'h7FFF;
      else if (v < -32768) return 16'h8000;
      else                 return v[15:0];
   endfunction

   function automatic logic [36:0] qget(input int i);
      if (i < got.size()) return got[i];
      return 'x;
   endfunction

   // Reference: beat index within frame picks kept samples; kept samples pair up; frame end flushes
   task automatic model_beat(input int dec, input logic [31:0] d, input logic last);
      bit kept, emitted;
      kept    = (midx % dec) == 0;
      emitted = 0;
      if (kept) begin
         if (($signed(d) > 32767 || $signed(d) < -32768) && expsat < 65535) expsat++;
         pend.push_back(sat16(d));
         if (pend.size() == 2) begin
            exp_q.push_back({last, 4'hF, pend[1], pend[0]});
            pend.delete();
            emitted = 1;
         end
      end
      if (last) begin
         if (pend.size() == 1) exp_q.push_back({1'b1, 4'h3, 16'h0000, pend[0]});
         else if (!emitted)    exp_q.push_back({1'b1, 4'h0, 32'h0});
         pend.delete();
         midx = 0;
      end else begin
         midx = (midx + 1) % dec;
      end
   endtask

   task automatic send(input int k, input int dec, input logic [31:0] d, input logic last);
      int   guard;
      logic acc;
      guard = 0;
      acc   = 0;
      s_tdata[k]  = d;
      s_tlast[k]  = last;
      s_tvalid[k] = 1'b1;
      while (!acc && guard < 50) begin
         if (rnd) m_tready[k] = 1'($urandom_range(0, 1));
         #1;
         acc = s_tready[k];
         @(posedge clk);
         #1;
         guard++;
      end
      s_tvalid[k] = 1'b0;
      if (acc) model_beat(dec, d, last);
      else     chk("accept_timeout", acc, 1'b1);
   endtask

   task automatic reset_inst(input int k);
      rst[k] = 1'b1;
      @(posedge clk);
      #1;
      rst[k] = 1'b0;
      pend.delete();
      midx   = 0;
      expsat = 0;
      got.delete();
      exp_q.delete();
      cur = k;
   endtask

   task automatic compare_all(input string tag);
      m_tready[cur] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) chk({tag, "_word"}, qget(i), exp_q[i]);
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int c0;
      logic [36:0] snap;
      logic [31:0] d;
      rst      = '1;
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      m_tready = '1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_tvalid", m_tvalid[k], 1'b0);
         chk("rst_tready", s_tready[k], 1'b0);
         chk("rst_out", {m_tlast[k], m_tstrb[k], m_tdata[k]}, 37'h0);
`ifdef SAT_COUNT_EN
         chk("rst_satc", satc[k], 16'h0);
`endif
      end
      rst = '0;
      #1;

      // DECIM=4 ramp, full-rate
      reset_inst(0);
      c0 = cyc;
      for (int i = 0; i < 16; i++) begin
         send(0, 4, i, 1'b0);
         if (i == 4)  chk("lat_w0", {m_tvalid[0], m_tdata[0]}, {1'b1, 32'h0004_0000});
         if (i == 12) chk("lat_w1", {m_tvalid[0], m_tdata[0]}, {1'b1, 32'h000C_0008});
      end
      chk("throughput", cyc - c0, 16);
      compare_all("ramp");

      // DECIM=1 saturation
      reset_inst(1);
      send(1, 1, 40000, 1'b0);
      send(1, 1, -40000, 1'b0);
      send(1, 1, 5, 1'b0);
      send(1, 1, -5, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("sat_w0", qget(0), {1'b0, 4'hF, 32'h8000_7FFF});
      chk("sat_w1", qget(1), {1'b0, 4'hF, 32'hFFFB_0005});
`ifdef SAT_COUNT_EN
      chk("sat_count", satc[1], 16'd2);
      chk("sat_count_model", satc[1], expsat);
`endif
      compare_all("sat");

      // DECIM=2 frames
      reset_inst(2);
      send(2, 2, 10, 1'b0);
      send(2, 2, 11, 1'b0);
      send(2, 2, 12, 1'b1);
      send(2, 2, 20, 1'b0);
      send(2, 2, 21, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("frm3_w", qget(0), {1'b1, 4'hF, 32'h000C_000A});
      chk("frm_next_kept", qget(1), {1'b1, 4'h3, 32'h0000_0014});
      compare_all("frame3");
      send(2, 2, 7, 1'b0);
      send(2, 2, 8, 1'b0);
      send(2, 2, 9, 1'b0);
      send(2, 2, 10, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("frm4_w", qget(0), {1'b0, 4'hF, 32'h0009_0007});
      chk("frm4_term", qget(1), {1'b1, 4'h0, 32'h0});
      compare_all("frame4");

      // Backpressure stall then random traffic with random downstream ready
      reset_inst(0);
      m_tready[0] = 1'b0;
      for (int i = 0; i < 5; i++) send(0, 4, 100 + i, 1'b0);
      snap = {m_tlast[0], m_tstrb[0], m_tdata[0]};
      chk("bp_pending", {m_tvalid[0], snap}, {1'b1, 1'b0, 4'hF, 32'h0068_0064});
      s_tvalid[0] = 1'b1;
      s_tdata[0]  = 32'd999;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_tready", s_tready[0], 1'b0);
         chk("bp_hold", {m_tvalid[0], m_tlast[0], m_tstrb[0], m_tdata[0]}, {1'b1, snap});
      end
      s_tvalid[0] = 1'b0;
      rnd = 1;
      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         if ($urandom_range(0, 2) != 0) d = $urandom_range(0, 65535) - 32768;
         send(0, 4, d, ($urandom_range(0, 7) == 0));
      end
      rnd = 0;
      compare_all("random");

      // Reset discards a pending word, then a held low lane
      reset_inst(1);
      m_tready[1] = 1'b0;
      send(1, 1, 5, 1'b0);
      send(1, 1, 6, 1'b0);
      chk("rst_mid_pending", m_tvalid[1], 1'b1);
      rst[1] = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_tvalid", m_tvalid[1], 1'b0);
      chk("rst_mid_tready", s_tready[1], 1'b0);
      rst[1] = 1'b0;
      m_tready[1] = 1'b1;
      pend.delete();
      midx = 0;
      send(1, 1, 3, 1'b0);
      reset_inst(1);
      send(1, 1, 1, 1'b0);
      send(1, 1, 2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_half_w0", qget(0), {1'b0, 4'hF, 32'h0002_0001});
      compare_all("rst_half");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
